// File: rtl/lsu_op_sequencer.sv
// ---------------------------------------------------------------------------
// lsu_op_sequencer
//
// Latches one decoded LSU memory operation and plays it out as 1..4
// sequential beats on the memory port. Each beat issues one request
// (valid/ready), waits for the acknowledge and, for reads, emits a single
// GPR writeback strobe. A one-cycle done pulse retires the operation.
//
// Optional feature macro: LSU_SEQ_TIMEOUT_EN
//   Defined   : 8-bit watchdog in WAIT; 255 cycles without mem_ack sets the
//               sticky error output, pulses done and abandons the operation.
//   Undefined : WAIT is unbounded, no watchdog logic, no error port.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   start, wfid, mem_op_rd,     decoded operation, sampled only in IDLE
//   mem_op_wr, mem_gpr,
//   mem_op_cnt, gpr_op_depth,
//   sgpr_wr_mask, gpr_base_addr,
//   mem_base_addr
//   mem_req_valid/ready         request handshake
//   mem_req_addr/wr/cnt/tag     request payload, stable while valid
//   mem_ack                     completion of the outstanding request
//   gpr_wr_en/addr/mask         read writeback strobe
//   gpr_rd_addr                 write-data source register (valid in REQ)
//   busy, done, done_wfid       status and retirement pulse
//   error                       watchdog flag (macro builds only)
// ---------------------------------------------------------------------------
module lsu_op_sequencer #(
   parameter int GPR_AW = 10,
   parameter int MEM_AW = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [5:0]        wfid,
   input  logic              mem_op_rd,
   input  logic              mem_op_wr,
   input  logic              mem_gpr,
   input  logic [5:0]        mem_op_cnt,
   input  logic [1:0]        gpr_op_depth,
   input  logic [3:0]        sgpr_wr_mask,
   input  logic [GPR_AW-1:0] gpr_base_addr,
   input  logic [MEM_AW-1:0] mem_base_addr,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [MEM_AW-1:0] mem_req_addr,
   output logic              mem_req_wr,
   output logic [5:0]        mem_req_cnt,
   output logic [7:0]        mem_req_tag,
   input  logic              mem_ack,
   output logic              gpr_wr_en,
   output logic [GPR_AW-1:0] gpr_wr_addr,
   output logic [3:0]        gpr_wr_mask,
   output logic [GPR_AW-1:0] gpr_rd_addr,
   output logic              busy,
   output logic              done,
   output logic [5:0]        done_wfid
`ifdef LSU_SEQ_TIMEOUT_EN
   ,
   output logic              error
`endif
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_WB,
      ST_DONE
   } state_t;

   state_t            state_reg, state_next;
   logic [1:0]        beat_reg, beat_next;

   // latched operation
   logic [5:0]        wfid_reg;
   logic              rd_reg;      // read wins when both rd and wr are set
   logic              wr_reg;      // write request (wr and not rd)
   logic              vgpr_reg;
   logic [5:0]        cnt_reg;
   logic [1:0]        depth_reg;
   logic [3:0]        mask_reg;
   logic [GPR_AW-1:0] gpr_base_reg;
   logic [MEM_AW-1:0] mem_base_reg;

   logic              accept;
   logic              last_beat;
   logic              timeout;
   logic [GPR_AW-1:0] gpr_addr_cur;

   assign accept    = (state_reg == ST_IDLE) && start;
   assign last_beat = (beat_reg == depth_reg);

`ifdef LSU_SEQ_TIMEOUT_EN
   logic [7:0] wdog_reg;
   logic       error_reg;

   // Counter value k means this is the (k+1)-th WAIT cycle; the 255th
   // cycle without an ack abandons the operation.
   assign timeout = (state_reg == ST_WAIT) && !mem_ack && (wdog_reg == 8'd254);
   assign error   = error_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wdog_reg  <= 8'd0;
         error_reg <= 1'b0;
      end else begin
         if ((state_reg == ST_REQ) && mem_req_ready)
            wdog_reg <= 8'd0;
         else if (state_reg == ST_WAIT)
            wdog_reg <= wdog_reg + 8'd1;
         if (timeout)
            error_reg <= 1'b1;
      end
   end
`else
   assign timeout = 1'b0;
`endif

   // next-state logic
   always_comb begin
      state_next = state_reg;
      beat_next  = beat_reg;
      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               beat_next  = 2'd0;
               state_next = (mem_op_rd || mem_op_wr) ? ST_REQ : ST_DONE;
            end
         end
         ST_REQ: begin
            if (mem_req_ready)
               state_next = ST_WAIT;
         end
         ST_WAIT: begin
            if (mem_ack) begin
               if (rd_reg) begin
                  state_next = ST_WB;
               end else if (last_beat) begin
                  state_next = ST_DONE;
               end else begin
                  beat_next  = beat_reg + 2'd1;
                  state_next = ST_REQ;
               end
            end else if (timeout) begin
               state_next = ST_DONE;
            end
         end
         ST_WB: begin
            if (last_beat) begin
               state_next = ST_DONE;
            end else begin
               beat_next  = beat_reg + 2'd1;
               state_next = ST_REQ;
            end
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
         beat_reg  <= 2'd0;
      end else begin
         state_reg <= state_next;
         beat_reg  <= beat_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wfid_reg     <= 6'd0;
         rd_reg       <= 1'b0;
         wr_reg       <= 1'b0;
         vgpr_reg     <= 1'b0;
         cnt_reg      <= 6'd0;
         depth_reg    <= 2'd0;
         mask_reg     <= 4'd0;
         gpr_base_reg <= '0;
         mem_base_reg <= '0;
      end else if (accept) begin
         wfid_reg     <= wfid;
         rd_reg       <= mem_op_rd;
         wr_reg       <= mem_op_wr && !mem_op_rd;
         vgpr_reg     <= mem_gpr;
         cnt_reg      <= mem_op_cnt;
         depth_reg    <= gpr_op_depth;
         mask_reg     <= sgpr_wr_mask;
         gpr_base_reg <= gpr_base_addr;
         mem_base_reg <= mem_base_addr;
      end
   end

   // VGPR beats step one register / 4 bytes; SGPR beats step four
   // registers / 16 bytes. Sums wrap naturally at the port width.
   assign gpr_addr_cur = gpr_base_reg + (vgpr_reg ? GPR_AW'(beat_reg)
                                                  : GPR_AW'({beat_reg, 2'b00}));
   assign mem_req_addr = mem_base_reg + (vgpr_reg ? MEM_AW'({beat_reg, 2'b00})
                                                  : MEM_AW'({beat_reg, 4'b0000}));

   assign mem_req_valid = (state_reg == ST_REQ);
   assign mem_req_wr    = wr_reg;
   assign mem_req_cnt   = cnt_reg;
   assign mem_req_tag   = {beat_reg, wfid_reg};
   assign gpr_wr_en     = (state_reg == ST_WB);
   assign gpr_wr_addr   = gpr_addr_cur;
   assign gpr_rd_addr   = gpr_addr_cur;
   assign gpr_wr_mask   = vgpr_reg ? 4'b0001 : mask_reg;
   assign busy          = (state_reg != ST_IDLE);
   assign done          = (state_reg == ST_DONE);
   assign done_wfid     = wfid_reg;

endmodule
